// File: rtl/frame_sync_deser.sv
// Frame-sync hunter/deserialiser: HUNT->VERIFY->LOCKED on an MSB-first stream, one clk from last bit to data_valid.
// No backpressure (in_valid strobes only); define SYNC_TOL_EN to accept 1-bit sync errors once aligned.
module frame_sync_deser #(
    parameter logic [7:0] SYNC_WORD     = 8'h9A,
    parameter int         PAYLOAD_BYTES = 4,
    parameter int         LOCK_THRESH   = 2,
    parameter int         LOSS_THRESH   = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_bit,
    input  logic       in_valid,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       sof,
    output logic       locked,
    output logic [7:0] slip_cnt
);
    localparam int         F         = 8 * (1 + PAYLOAD_BYTES);
    localparam logic [6:0] LAST_BIT  = 7'(F - 1);
    localparam logic [6:0] SYNC_BIT0 = 7'(F - 8);
    localparam logic [2:0] LOCK_N    = 3'(LOCK_THRESH);
    localparam logic [2:0] LOSS_N    = 3'(LOSS_THRESH);

    typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;

    state_t     state, state_nx;
    logic [7:0] sh, sh_nx;
    logic [6:0] bit_cnt, bit_nx;
    logic [2:0] hits, hits_nx, misses, miss_nx;
    logic [7:0] dout_nx, slip_nx;
    logic       dv_nx, sof_nx;

    logic [7:0] win;
    logic       exact, chk, at_check;

    assign win      = {sh[6:0], in_bit};
    assign exact    = (win == SYNC_WORD);
    assign at_check = (bit_cnt == LAST_BIT);
`ifdef SYNC_TOL_EN
    assign chk = ($countones(win ^ SYNC_WORD) <= 1);
`else
    assign chk = exact;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= HUNT;
            sh         <= '0;
            bit_cnt    <= '0;
            hits       <= '0;
            misses     <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            sof        <= 1'b0;
            locked     <= 1'b0;
            slip_cnt   <= '0;
        end else begin
            state      <= state_nx;
            sh         <= sh_nx;
            bit_cnt    <= bit_nx;
            hits       <= hits_nx;
            misses     <= miss_nx;
            data_out   <= dout_nx;
            data_valid <= dv_nx;
            sof        <= sof_nx;
            locked     <= (state_nx == LOCKED);
            slip_cnt   <= slip_nx;
        end
    end

    always_comb begin
        state_nx = state;
        sh_nx    = sh;
        bit_nx   = bit_cnt;
        hits_nx  = hits;
        miss_nx  = misses;
        dout_nx  = data_out;
        dv_nx    = 1'b0;
        sof_nx   = 1'b0;
        slip_nx  = slip_cnt;
        if (in_valid) begin
            sh_nx = win;
            case (state)
                HUNT: begin
                    if (exact) begin
                        bit_nx  = '0;
                        hits_nx = 3'd1;
                        miss_nx = '0;
                        state_nx = (LOCK_THRESH == 1) ? LOCKED : VERIFY;
                    end
                end
                VERIFY: begin
                    bit_nx = bit_cnt + 7'd1;
                    if (at_check) begin
                        bit_nx = '0;
                        if (chk) begin
                            hits_nx = hits + 3'd1;
                            if (hits + 3'd1 >= LOCK_N) begin
                                state_nx = LOCKED;
                                miss_nx  = '0;
                            end
                        end else begin
                            state_nx = HUNT;
                            hits_nx  = '0;
                        end
                    end
                end
                LOCKED: begin
                    bit_nx = bit_cnt + 7'd1;
                    if (bit_cnt[2:0] == 3'd7 && bit_cnt < SYNC_BIT0) begin
                        dout_nx = win;
                        dv_nx   = 1'b1;
                        sof_nx  = (bit_cnt == 7'd7);
                    end
                    if (at_check) begin
                        bit_nx = '0;
                        if (chk) begin
                            miss_nx = '0;
                        end else if (misses + 3'd1 >= LOSS_N) begin
                            // Flywheel exhausted: restart the hunt on the next bit.
                            state_nx = HUNT;
                            hits_nx  = '0;
                            miss_nx  = '0;
                            slip_nx  = (slip_cnt == 8'hFF) ? slip_cnt : slip_cnt + 8'd1;
                        end else begin
                            miss_nx = misses + 3'd1;
                        end
                    end
                end
                default: state_nx = HUNT;
            endcase
        end
    end
endmodule

// File: tb/tb_frame_sync_deser.sv
// Directed-frame bench: stimulus queues expected bytes, a negedge monitor pops and compares them.
module tb_frame_sync_deser;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_bit = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] data_out;
    logic       data_valid;
    logic       sof;
    logic       locked;
    logic [7:0] slip_cnt;

    frame_sync_deser dut (
        .clk(clk), .rst(rst), .in_bit(in_bit), .in_valid(in_valid),
        .data_out(data_out), .data_valid(data_valid), .sof(sof),
        .locked(locked), .slip_cnt(slip_cnt)
    );

    always #5 clk = ~clk;

`ifdef SYNC_TOL_EN
    localparam bit TOL = 1'b1;
`else
    localparam bit TOL = 1'b0;
`endif
    localparam logic [31:0] P1 = 32'h11223344;
    localparam logic [31:0] P2 = 32'h01020304;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int gap = 0;

    logic [7:0] q_dat[$];
    bit         q_sof[$];
    int         q_cyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every data_valid must match the oldest expected byte, its sof flag and its cycle.
    always @(negedge clk) begin
        if (!rst && data_valid) begin
            if (q_dat.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_byte: got %0h expected none (t=%0t)", data_out, $time);
            end else begin
                check("byte", data_out, q_dat.pop_front());
                check("sof", sof, q_sof.pop_front());
                check("latency_cycle", cyc, q_cyc.pop_front());
            end
        end
    end

    task automatic send_bit(input logic b, input bit last, input logic [7:0] exp,
                            input bit is_sof, input bit emit);
        @(negedge clk);
        in_bit   = b;
        in_valid = 1'b1;
        if (emit && last) begin
            q_dat.push_back(exp);
            q_sof.push_back(is_sof);
            q_cyc.push_back(cyc + 1);
        end
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit emit, input bit is_sof);
        for (int i = 7; i >= 0; i--) send_bit(b[i], i == 0, b, is_sof, emit);
    endtask

    task automatic send_frame(input logic [7:0] sync, input logic [31:0] pay, input bit emit);
        send_byte(sync, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) send_byte(pay[31-8*k -: 8], emit, k == 0);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    task automatic drain(input string name);
        idle(3);
        check(name, q_dat.size(), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        #2;
        check("rst_data_out", data_out, 0);
        check("rst_data_valid", data_valid, 0);
        check("rst_sof", sof, 0);
        check("rst_locked", locked, 0);
        check("rst_slip", slip_cnt, 0);
        do_reset();

        // Clean acquisition: second sync locks, its payload is emitted
        send_frame(8'h9A, P1, 1'b0);
        idle(2);
        check("p1_verify_unlocked", locked, 0);
        send_frame(8'h9A, P1, 1'b1);
        idle(2);
        check("p1_locked", locked, 1);
        send_frame(8'h9A, P1, 1'b1);
        drain("p1_drain");

        // Flywheel: single miss tolerated, match clears misses, three in a row slips
        send_frame(8'h00, P1, 1'b1);
        idle(2);
        check("fly_one_miss_locked", locked, 1);
        send_frame(8'h9A, P1, 1'b1);
        send_frame(8'h00, P1, 1'b1);
        send_frame(8'h00, P1, 1'b1);
        idle(2);
        check("fly_two_miss_locked", locked, 1);
        send_frame(8'h00, P1, 1'b0);
        idle(2);
        check("loss_unlocked", locked, 0);
        check("loss_slip", slip_cnt, 1);
        drain("loss_drain");
        do_reset();
        check("reset_clears_slip", slip_cnt, 0);

        // Single-bit sync error (9B) while locked
        send_frame(8'h9A, P2, 1'b0);
        send_frame(8'h9A, P2, 1'b1);
        send_frame(8'h9B, P2, 1'b1);
        send_frame(8'h9B, P2, 1'b1);
        send_frame(8'h9B, P2, TOL);
        idle(2);
        check("tol_locked", locked, TOL);
        check("tol_slip", slip_cnt, !TOL);
        drain("tol_drain");
        do_reset();

        // Unaligned start: 5 leading bits before the first sync
        send_bit(1'b0, 0, 8'h00, 0, 0);
        send_bit(1'b1, 0, 8'h00, 0, 0);
        send_bit(1'b1, 0, 8'h00, 0, 0);
        send_bit(1'b0, 0, 8'h00, 0, 0);
        send_bit(1'b1, 0, 8'h00, 0, 0);
        send_frame(8'h9A, P2, 1'b0);
        send_frame(8'h9A, P2, 1'b1);
        send_frame(8'h9A, P2, 1'b1);
        idle(2);
        check("offset_locked", locked, 1);
        drain("offset_drain");
        do_reset();

        // False sync: stray 9A sends VERIFY down a misaligned path that fails at byte 03
        send_byte(8'h9A, 1'b0, 1'b0);
        send_byte(8'h00, 1'b0, 1'b0);
        send_frame(8'h9A, P2, 1'b0);
        idle(2);
        check("false_sync_unlocked", locked, 0);
        send_frame(8'h9A, P2, 1'b0);
        send_frame(8'h9A, P2, 1'b1);
        send_frame(8'h9A, P2, 1'b1);
        idle(2);
        check("false_sync_relocked", locked, 1);
        drain("false_sync_drain");
        do_reset();

        // Sparse strobes (1 of 3 cycles), then asynchronous reset mid-frame
        gap = 2;
        send_frame(8'h9A, P1, 1'b0);
        send_frame(8'h9A, P1, 1'b1);
        send_frame(8'h9A, P1, 1'b1);
        send_byte(8'h9A, 1'b0, 1'b0);
        for (int i = 7; i >= 4; i--) send_bit(P1[24+i], 0, 8'h00, 0, 0);
        check("pre_rst_locked", locked, 1);
        #3;
        rst = 1'b1;
        #1;
        check("mid_rst_data_out", data_out, 0);
        check("mid_rst_data_valid", data_valid, 0);
        check("mid_rst_sof", sof, 0);
        check("mid_rst_locked", locked, 0);
        check("mid_rst_slip", slip_cnt, 0);
        in_valid = 1'b0;
        gap = 0;
        idle(2);
        rst = 1'b0;
        for (int i = 3; i >= 0; i--) send_bit(P1[24+i], 0, 8'h00, 0, 0);
        idle(2);
        check("post_rst_unlocked", locked, 0);
        drain("final_drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
